// File: rtl/axi4_stream_pkg.sv
// -----------------------------------------------------------------------------
// axi4_stream_pkg
// Shared definitions for the AXI4-Stream demo path (pattern generator and the
// sideband/TLAST stage that follows it).
//   state_t          : pattern generator FSM encoding
//   TX_SIZE_DEFAULT  : default trans_size (beats per frame minus 1)
//   keep_width()     : TKEEP width derived from a TDATA width
// -----------------------------------------------------------------------------
package axi4_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   // trans_size convention: a frame carries trans_size+1 beats.
   localparam logic [31:0] TX_SIZE_DEFAULT = 32'd7;

   function automatic int keep_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/axi4_stream_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// axi4_stream_pattern_gen_if
// AXI4-Stream beat bundle between the pattern generator and its consumer.
//   TVALID, TDATA, TLAST, TKEEP : driven by the master
//   TREADY                      : driven by the slave
// Modports: master (source side), slave (sink side).
// -----------------------------------------------------------------------------
interface axi4_stream_pattern_gen_if #(
   parameter int DATA_WIDTH = 32
);
   import axi4_stream_pkg::*;

   logic                                TVALID;
   logic                                TREADY;
   logic [DATA_WIDTH-1:0]               TDATA;
   logic                                TLAST;
   logic [keep_width(DATA_WIDTH)-1:0]   TKEEP;

   modport master (output TVALID, output TDATA, output TLAST, output TKEEP, input TREADY);
   modport slave  (input  TVALID, input  TDATA, input  TLAST, input  TKEEP, output TREADY);

endinterface

// File: rtl/axi4_stream_pattern_gen.sv
// -----------------------------------------------------------------------------
// axi4_stream_pattern_gen
// Framed counting-pattern source with a full TVALID/TREADY handshake.
// Ports:
//   ACLK, RST      : clock, synchronous active-high reset
//   START, STOP    : run start strobe (IDLE only) / graceful stop request
//   trans_size     : beats per frame minus 1   (sampled at START)
//   frame_count    : frames per run, 0 = until STOP (sampled at START)
//   seed           : first TDATA of the run     (sampled at START)
//   BUSY, DONE     : not-IDLE flag / one-cycle end-of-run pulse
//   frames_sent    : frames completed in the current or last run
//   m_axis         : AXI4-Stream master (TVALID/TDATA/TLAST/TKEEP, TREADY)
// -----------------------------------------------------------------------------
module axi4_stream_pattern_gen
   import axi4_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int INC        = 1,
   parameter int GAP_CYCLES = 0
) (
   input  logic                   ACLK,
   input  logic                   RST,
   input  logic                   START,
   input  logic                   STOP,
   input  logic [31:0]            trans_size,
   input  logic [15:0]            frame_count,
   input  logic [DATA_WIDTH-1:0]  seed,
   output logic                   BUSY,
   output logic                   DONE,
   output logic [15:0]            frames_sent,
   axi4_stream_pattern_gen_if.master m_axis
);

   localparam int KEEP_W = keep_width(DATA_WIDTH);

   state_t                 state_q, state_d;
   logic                   tvalid_q, tvalid_d;
   logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
   logic                   tlast_q, tlast_d;
   logic                   done_q, done_d;
   logic [15:0]            frames_sent_q, frames_sent_d;
   logic [31:0]            beat_cnt_q, beat_cnt_d;
   logic [31:0]            gap_cnt_q, gap_cnt_d;
   logic                   stop_pending_q, stop_pending_d;
   logic [31:0]            size_q, size_d;
   logic [15:0]            fcount_q, fcount_d;
   logic [DATA_WIDTH-1:0]  seed_q, seed_d;

   logic                   xfer;
   logic                   last_frame;
   logic [15:0]            frames_inc;

   assign xfer = tvalid_q && m_axis.TREADY;

   // Compare in 17 bits so a 16'hFFFF frame_count still terminates.
   assign last_frame = (fcount_q != 16'd0) &&
                       (({1'b0, frames_sent_q} + 17'd1) == {1'b0, fcount_q});

   assign frames_inc = (frames_sent_q == 16'hFFFF) ? frames_sent_q : frames_sent_q + 16'd1;

   always_ff @(posedge ACLK) begin
      if (RST) begin
         state_q        <= ST_IDLE;
         tvalid_q       <= 1'b0;
         tdata_q        <= '0;
         tlast_q        <= 1'b0;
         done_q         <= 1'b0;
         frames_sent_q  <= '0;
         beat_cnt_q     <= '0;
         gap_cnt_q      <= '0;
         stop_pending_q <= 1'b0;
         size_q         <= '0;
         fcount_q       <= '0;
         seed_q         <= '0;
      end else begin
         state_q        <= state_d;
         tvalid_q       <= tvalid_d;
         tdata_q        <= tdata_d;
         tlast_q        <= tlast_d;
         done_q         <= done_d;
         frames_sent_q  <= frames_sent_d;
         beat_cnt_q     <= beat_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         stop_pending_q <= stop_pending_d;
         size_q         <= size_d;
         fcount_q       <= fcount_d;
         seed_q         <= seed_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      tvalid_d       = tvalid_q;
      tdata_d        = tdata_q;
      tlast_d        = tlast_q;
      done_d         = 1'b0;
      frames_sent_d  = frames_sent_q;
      beat_cnt_d     = beat_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      stop_pending_d = stop_pending_q;
      size_d         = size_q;
      fcount_d       = fcount_q;
      seed_d         = seed_q;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d        = ST_LOAD;
               size_d         = trans_size;
               fcount_d       = frame_count;
               seed_d         = seed;
               frames_sent_d  = '0;
               stop_pending_d = 1'b0;
            end
         end

         ST_LOAD: begin
            tdata_d    = seed_q;
            beat_cnt_d = '0;
            tlast_d    = (size_q == 32'd0);
            tvalid_d   = 1'b1;
            state_d    = ST_STREAM;
         end

         ST_STREAM: begin
            if (xfer) begin
               // Data keeps counting across frame boundaries.
               tdata_d = tdata_q + DATA_WIDTH'(INC);
               if (!tlast_q) begin
                  // beat_cnt never exceeds size_q-1 here, so +1 cannot wrap.
                  beat_cnt_d = beat_cnt_q + 32'd1;
                  tlast_d    = ((beat_cnt_q + 32'd1) == size_q);
                  if (STOP) begin
                     stop_pending_d = 1'b1;
                  end
               end else begin
                  frames_sent_d = frames_inc;
                  beat_cnt_d    = '0;
                  tlast_d       = (size_q == 32'd0);
                  if (last_frame || stop_pending_q || STOP) begin
                     tvalid_d       = 1'b0;
                     tlast_d        = 1'b0;
                     done_d         = 1'b1;
                     stop_pending_d = 1'b0;
                     state_d        = ST_IDLE;
                  end else if (GAP_CYCLES > 0) begin
                     tvalid_d  = 1'b0;
                     gap_cnt_d = '0;
                     state_d   = ST_GAP;
                  end
               end
            end else if (STOP) begin
               stop_pending_d = 1'b1;
            end
         end

         ST_GAP: begin
            if (STOP) begin
               tlast_d = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (gap_cnt_q == 32'(GAP_CYCLES - 1)) begin
               gap_cnt_d = '0;
               tvalid_d  = 1'b1;
               state_d   = ST_STREAM;
            end else begin
               gap_cnt_d = gap_cnt_q + 32'd1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign m_axis.TVALID = tvalid_q;
   assign m_axis.TDATA  = tdata_q;
   assign m_axis.TLAST  = tlast_q;
   assign m_axis.TKEEP  = {KEEP_W{tvalid_q}};

   assign BUSY        = (state_q != ST_IDLE);
   assign DONE        = done_q;
   assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_axi4_stream_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_axi4_stream_pattern_gen
// Directed bench for axi4_stream_pattern_gen. Two instances share the control
// inputs and TREADY: dut_g with GAP_CYCLES=2 and dut_b with back-to-back frames.
// -----------------------------------------------------------------------------
module tb_axi4_stream_pattern_gen;

   logic        ACLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic        STOP = 1'b0;
   logic        TREADY = 1'b1;
   logic [31:0] trans_size = '0;
   logic [15:0] frame_count = '0;
   logic [31:0] seed = '0;
   logic        busy_g, done_g, busy_b, done_b;
   logic [15:0] fs_g, fs_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] gd[$];
   logic        gl[$];
   logic [31:0] bd[$];
   logic [63:0] vb, vbb;
   logic        done_seen;
   logic [15:0] fs_at_done;

   always #5 ACLK = ~ACLK;

   axi4_stream_pattern_gen_if #(.DATA_WIDTH(32)) g_if ();
   axi4_stream_pattern_gen_if #(.DATA_WIDTH(32)) b_if ();
   assign g_if.TREADY = TREADY;
   assign b_if.TREADY = TREADY;

   axi4_stream_pattern_gen #(.DATA_WIDTH(32), .INC(1), .GAP_CYCLES(2)) dut_g (
      .ACLK(ACLK), .RST(RST), .START(START), .STOP(STOP),
      .trans_size(trans_size), .frame_count(frame_count), .seed(seed),
      .BUSY(busy_g), .DONE(done_g), .frames_sent(fs_g), .m_axis(g_if)
   );

   axi4_stream_pattern_gen #(.DATA_WIDTH(32), .INC(1), .GAP_CYCLES(0)) dut_b (
      .ACLK(ACLK), .RST(RST), .START(START), .STOP(STOP),
      .trans_size(trans_size), .frame_count(frame_count), .seed(seed),
      .BUSY(busy_b), .DONE(done_b), .frames_sent(fs_b), .m_axis(b_if)
   );

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      START = 1'b0;
      STOP = 1'b0;
      TREADY = 1'b1;
      tick();
      tick();
      RST = 1'b0;
   endtask

   // Launches a run at c=0 and records dut_g beats until its DONE pulse.
   // ready_mode 1 drives TREADY 1,0,0,1,0,0,...; stop_at raises STOP on the
   // cycle beat number stop_at transfers; ign_at pulses START with new settings.
   task automatic collect(input int max_cyc, input int ready_mode,
                          input int stop_at, input int ign_at);
      logic        stall;
      logic [31:0] pd;
      logic        pl;
      stall = 1'b0;
      pd = '0;
      pl = 1'b0;
      gd.delete();
      gl.delete();
      bd.delete();
      vb = '0;
      vbb = '0;
      done_seen = 1'b0;
      fs_at_done = '0;
      for (int c = 0; c < max_cyc; c++) begin
         TREADY = (ready_mode == 0) ? 1'b1 : ((c % 3) == 0);
         START = (c == 0) || (c == ign_at);
         if (c == ign_at) begin
            seed = 32'hDEAD0000;
            trans_size = 32'd0;
         end
         if (stall) begin
            chk("hold_valid", 64'(g_if.TVALID), 64'd1);
            chk("hold_data", 64'(g_if.TDATA), 64'(pd));
            chk("hold_last", 64'(g_if.TLAST), 64'(pl));
         end
         STOP = g_if.TVALID && TREADY && (gd.size() == stop_at);
         if (c < 64) begin
            vb[c] = g_if.TVALID;
            vbb[c] = b_if.TVALID;
         end
         if (g_if.TVALID && TREADY) begin
            gd.push_back(g_if.TDATA);
            gl.push_back(g_if.TLAST);
         end
         if (b_if.TVALID && TREADY) bd.push_back(b_if.TDATA);
         if (done_g) begin
            done_seen = 1'b1;
            fs_at_done = fs_g;
            break;
         end
         stall = g_if.TVALID && !TREADY;
         pd = g_if.TDATA;
         pl = g_if.TLAST;
         tick();
      end
      START = 1'b0;
      STOP = 1'b0;
      chk("done_within_budget", 64'(done_seen), 64'd1);
   endtask

   task automatic chk_beats(input string tag, input logic [31:0] first,
                            input int n, input int per_frame);
      chk({tag, "_count"}, 64'(gd.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < gd.size()) begin
            chk({tag, "_data"}, 64'(gd[i]), 64'(32'(first + 32'(i))));
            chk({tag, "_last"}, 64'(gl[i]), 64'((i % per_frame) == per_frame - 1));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state ----
      do_reset();
      chk("rst_tvalid", 64'(g_if.TVALID), 64'd0);
      chk("rst_tlast", 64'(g_if.TLAST), 64'd0);
      chk("rst_tkeep", 64'(g_if.TKEEP), 64'd0);
      chk("rst_tdata", 64'(g_if.TDATA), 64'd0);
      chk("rst_busy", 64'(busy_g), 64'd0);
      chk("rst_done", 64'(done_g), 64'd0);
      chk("rst_frames", 64'(fs_g), 64'd0);

      // ---- basic frame: 10,11,12,13 with latency check ----
      trans_size = 32'd3;
      frame_count = 16'd1;
      seed = 32'h10;
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("basic_load_tvalid", 64'(g_if.TVALID), 64'd0);
      chk("basic_load_busy", 64'(busy_g), 64'd1);
      tick();
      chk("basic_first_tvalid", 64'(g_if.TVALID), 64'd1);
      chk("basic_first_tkeep", 64'(g_if.TKEEP), 64'hF);
      chk("basic_b0_data", 64'(g_if.TDATA), 64'h10);
      chk("basic_b0_last", 64'(g_if.TLAST), 64'd0);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("basic_data", 64'(g_if.TDATA), 64'(32'h10 + i));
         chk("basic_last", 64'(g_if.TLAST), 64'(i == 3));
      end
      tick();
      chk("basic_done", 64'(done_g), 64'd1);
      chk("basic_done_busy", 64'(busy_g), 64'd0);
      chk("basic_done_tvalid", 64'(g_if.TVALID), 64'd0);
      chk("basic_frames", 64'(fs_g), 64'd1);
      tick();
      chk("basic_done_pulse", 64'(done_g), 64'd0);
      $display("basic frame: 4 beats from 0x10 checked");

      // ---- backpressure: TREADY 1,0,0,... ----
      do_reset();
      trans_size = 32'd3;
      frame_count = 16'd1;
      seed = 32'h10;
      collect(40, 1, -1, -1);
      chk_beats("bp", 32'h10, 4, 4);
      chk("bp_frames", 64'(fs_at_done), 64'd1);
      $display("backpressure frame: %0d beats recorded", gd.size());

      // ---- multi-frame with 2-cycle gap (and back-to-back on dut_b) ----
      do_reset();
      trans_size = 32'd1;
      frame_count = 16'd3;
      seed = 32'h0;
      collect(40, 0, -1, -1);
      chk_beats("gap", 32'h0, 6, 2);
      chk("gap_valid_pattern", vb, 64'b0110011001100);
      chk("gap_frames", 64'(fs_at_done), 64'd3);
      chk("b2b_valid_pattern", vbb, 64'b0000011111100);
      chk("b2b_count", 64'(bd.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < bd.size()) chk("b2b_data", 64'(bd[i]), 64'(i));
      end
      chk("b2b_frames", 64'(fs_b), 64'd3);
      $display("multi-frame: gap and back-to-back runs of 3 frames checked");

      // ---- graceful STOP, START ignored while busy ----
      do_reset();
      trans_size = 32'd7;
      frame_count = 16'd0;
      seed = 32'h100;
      collect(60, 0, 10, 5);
      chk_beats("stop", 32'h100, 16, 8);
      chk("stop_frames", 64'(fs_at_done), 64'd2);
      tick();
      chk("stop_idle_busy", 64'(busy_g), 64'd0);
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
      chk("stop_in_idle_busy", 64'(busy_g), 64'd0);
      chk("stop_in_idle_frames", 64'(fs_g), 64'd2);
      $display("graceful stop: %0d beats, frames_sent=%0d", gd.size(), fs_at_done);

      // ---- single-beat frames with TDATA wrap ----
      do_reset();
      trans_size = 32'd0;
      frame_count = 16'd3;
      seed = 32'hFFFFFFFE;
      collect(40, 0, -1, -1);
      chk("wrap_count", 64'(gd.size()), 64'd3);
      if (gd.size() == 3) begin
         chk("wrap_d0", 64'(gd[0]), 64'hFFFFFFFE);
         chk("wrap_d1", 64'(gd[1]), 64'hFFFFFFFF);
         chk("wrap_d2", 64'(gd[2]), 64'h00000000);
         chk("wrap_l0", 64'(gl[0]), 64'd1);
         chk("wrap_l1", 64'(gl[1]), 64'd1);
         chk("wrap_l2", 64'(gl[2]), 64'd1);
      end
      chk("wrap_frames", 64'(fs_at_done), 64'd3);
      $display("single-beat wrap: 3 frames checked");

      // ---- reset mid-frame during beat 5 with TREADY low ----
      do_reset();
      trans_size = 32'd3;
      frame_count = 16'd0;
      seed = 32'h50;
      START = 1'b1;
      tick();
      START = 1'b0;
      repeat (5) tick();
      chk("mid_gap_tvalid", 64'(g_if.TVALID), 64'd0);
      chk("mid_gap_frames", 64'(fs_g), 64'd1);
      repeat (3) tick();
      chk("mid_beat5_data", 64'(g_if.TDATA), 64'h55);
      TREADY = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      TREADY = 1'b1;
      chk("mid_rst_tvalid", 64'(g_if.TVALID), 64'd0);
      chk("mid_rst_busy", 64'(busy_g), 64'd0);
      chk("mid_rst_frames", 64'(fs_g), 64'd0);
      chk("mid_rst_tkeep", 64'(g_if.TKEEP), 64'd0);
      trans_size = 32'd1;
      frame_count = 16'd1;
      seed = 32'h900;
      START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      chk("restart_d0", 64'(g_if.TDATA), 64'h900);
      chk("restart_l0", 64'(g_if.TLAST), 64'd0);
      tick();
      chk("restart_d1", 64'(g_if.TDATA), 64'h901);
      chk("restart_l1", 64'(g_if.TLAST), 64'd1);
      tick();
      chk("restart_done", 64'(done_g), 64'd1);
      chk("restart_frames", 64'(fs_g), 64'd1);
      $display("reset mid-frame and restart checked");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
